// File: rtl/wave_period_meter.sv
// Measures the rising-edge period of an asynchronous square wave and reports the average of 2**AVG_LOG2 periods.
// Short edges are rejected as glitches. Loss of signal is declared when no edge arrives within MAX_PERIOD cycles.
module wave_period_meter #(
  parameter int CNT_W      = 20,
  parameter int MIN_PERIOD = 20000,
  parameter int MAX_PERIOD = 500000,
  parameter int AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wave_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             signal_present,
  output logic             glitch
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int NW    = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [NW-1:0]    N_AVG = NW'(1 << AVG_LOG2);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MEASURE = 1'b1;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [NW-1:0]    r_n;
  logic [CNT_W-1:0] r_period_out;
  logic             r_period_valid;
  logic             r_signal_present;
  logic             r_glitch;

  logic             w_edge;
  logic             w_short;
  logic             w_accept;
  logic             w_timeout;
  logic [ACC_W-1:0] w_acc_sum;
  logic [ACC_W-1:0] w_acc_avg;
  logic [NW-1:0]    w_n_next;
  logic             w_block_done;
  logic [CNT_W-1:0] w_cnt_inc;

  // Two flops resolve metastability; the third flop gives the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= wave_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge       = r_s2 & ~r_s3;
  assign w_short      = (r_cnt < MIN_C);
  assign w_accept     = w_edge & ~w_short & (r_cnt <= MAX_C);
  assign w_timeout    = ~w_edge & (r_cnt == MAX_C);
  assign w_acc_sum    = r_acc + ACC_W'(r_cnt);
  assign w_acc_avg    = w_acc_sum >> AVG_LOG2;
  assign w_n_next     = r_n + NW'(1);
  assign w_block_done = (w_n_next == N_AVG);
  assign w_cnt_inc    = (r_cnt == MAX_C) ? r_cnt : r_cnt + ONE_C;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_acc            <= '0;
      r_n              <= '0;
      r_period_out     <= '0;
      r_period_valid   <= 1'b0;
      r_signal_present <= 1'b0;
      r_glitch         <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      r_glitch       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_cnt   <= ONE_C;
            r_acc   <= '0;
            r_n     <= '0;
            r_state <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (w_edge && w_short) begin
            r_glitch <= 1'b1;
            r_cnt    <= w_cnt_inc;
          end else if (w_accept) begin
            // The edge closing one averaging block also opens the next one.
            r_cnt <= ONE_C;
            if (w_block_done) begin
              r_period_out     <= w_acc_avg[CNT_W-1:0];
              r_period_valid   <= 1'b1;
              r_signal_present <= 1'b1;
              r_acc            <= '0;
              r_n              <= '0;
            end else begin
              r_acc <= w_acc_sum;
              r_n   <= w_n_next;
            end
          end else if (w_timeout) begin
            r_signal_present <= 1'b0;
            r_acc            <= '0;
            r_n              <= '0;
            r_cnt            <= '0;
            r_state          <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign period_out     = r_period_out;
  assign period_valid   = r_period_valid;
  assign signal_present = r_signal_present;
  assign glitch         = r_glitch;

endmodule

// File: tb/tb_wave_period_meter.sv
// Directed bench for wave_period_meter with MIN_PERIOD=10, MAX_PERIOD=100, averaging 4 periods.
module tb_wave_period_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wave_in;
  logic [19:0] period_out;
  logic        period_valid;
  logic        signal_present;
  logic        glitch;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int glitch_cnt = 0;
  int collide = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;

  wave_period_meter #(
    .CNT_W(20), .MIN_PERIOD(10), .MAX_PERIOD(100), .AVG_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .wave_in(wave_in), .period_out(period_out),
    .period_valid(period_valid), .signal_present(signal_present), .glitch(glitch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (period_valid) begin
      valid_cnt      <= valid_cnt + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
    end
    if (glitch) glitch_cnt <= glitch_cnt + 1;
    if (period_valid && glitch) collide <= collide + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave_period(input int h, input int l);
    wave_in = 1'b1;
    step(h);
    wave_in = 1'b0;
    step(l);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wave_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wave_in = ~wave_in;
      step(1);
      checks++; if (period_out !== 20'd0) $display("FAIL reset_period_out cyc%0d got %0d want 0", i, period_out); else passes++;
      checks++; if (period_valid !== 1'b0) $display("FAIL reset_valid cyc%0d got %b want 0", i, period_valid); else passes++;
      checks++; if (signal_present !== 1'b0) $display("FAIL reset_present cyc%0d got %b want 0", i, signal_present); else passes++;
      checks++; if (glitch !== 1'b0) $display("FAIL reset_glitch cyc%0d got %b want 0", i, glitch); else passes++;
    end
    wave_in = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_lock();
    int v0;
    v0 = valid_cnt;
    repeat (4) wave_period(20, 20);
    checks++; if (valid_cnt !== v0) $display("FAIL lock_early_valid got %0d want %0d", valid_cnt - v0, 0); else passes++;
    checks++; if (signal_present !== 1'b0) $display("FAIL lock_early_present got %b want 0", signal_present); else passes++;
    // Fifth rise: two sync flops plus the edge flop put the valid pulse 3 clock edges after the drive.
    wave_in = 1'b1;
    step(2);
    checks++; if (period_valid !== 1'b0) $display("FAIL lock_valid_too_soon got %b want 0", period_valid); else passes++;
    step(1);
    checks++; if (period_valid !== 1'b1) $display("FAIL lock_valid_latency got %b want 1", period_valid); else passes++;
    checks++; if (period_out !== 20'd40) $display("FAIL lock_period got %0d want 40", period_out); else passes++;
    checks++; if (signal_present !== 1'b1) $display("FAIL lock_present got %b want 1", signal_present); else passes++;
    step(17);
    wave_in = 1'b0;
    step(20);
    checks++; if (valid_cnt !== v0 + 1) $display("FAIL lock_valid_count got %0d want %0d", valid_cnt - v0, 1); else passes++;
    repeat (4) wave_period(20, 20);
    checks++; if (valid_cnt !== v0 + 2) $display("FAIL lock_second_valid got %0d want %0d", valid_cnt - v0, 2); else passes++;
    checks++; if (last_valid_cyc - prev_valid_cyc !== 160) $display("FAIL lock_valid_spacing got %0d want 160", last_valid_cyc - prev_valid_cyc); else passes++;
  endtask

  task automatic test_average();
    int v0;
    v0 = valid_cnt;
    // Previous rise already closes a 40-cycle interval; these add 41, 42, 43.
    wave_period(20, 21);
    wave_period(20, 22);
    wave_period(20, 23);
    wave_period(20, 20);
    checks++; if (valid_cnt !== v0 + 1) $display("FAIL avg_valid_count got %0d want 1", valid_cnt - v0); else passes++;
    checks++; if (period_out !== 20'd41) $display("FAIL avg_period got %0d want 41", period_out); else passes++;
  endtask

  task automatic test_glitch();
    int v0, g0;
    v0 = valid_cnt;
    g0 = glitch_cnt;
    repeat (4) begin
      wave_in = 1'b1; step(2);
      wave_in = 1'b0; step(3);
      wave_in = 1'b1; step(2);
      wave_in = 1'b0; step(33);
    end
    checks++; if (glitch_cnt !== g0 + 4) $display("FAIL glitch_count got %0d want 4", glitch_cnt - g0); else passes++;
    checks++; if (valid_cnt !== v0 + 1) $display("FAIL glitch_valid_count got %0d want 1", valid_cnt - v0); else passes++;
    checks++; if (period_out !== 20'd40) $display("FAIL glitch_period got %0d want 40", period_out); else passes++;
  endtask

  task automatic test_timeout();
    int v0;
    v0 = valid_cnt;
    wave_in = 1'b1;
    step(20);
    wave_in = 1'b0;
    // Accepted edge lands 3 clock edges after the drive; drop is 100 cycles later.
    step(82);
    checks++; if (signal_present !== 1'b1) $display("FAIL timeout_early got %b want 1", signal_present); else passes++;
    step(1);
    checks++; if (signal_present !== 1'b0) $display("FAIL timeout_drop got %b want 0", signal_present); else passes++;
    checks++; if (valid_cnt !== v0) $display("FAIL timeout_no_valid got %0d want 0", valid_cnt - v0); else passes++;
    checks++; if (period_out !== 20'd40) $display("FAIL timeout_hold got %0d want 40", period_out); else passes++;
    repeat (4) wave_period(20, 20);
    checks++; if (valid_cnt !== v0) $display("FAIL restart_early_valid got %0d want 0", valid_cnt - v0); else passes++;
    checks++; if (signal_present !== 1'b0) $display("FAIL restart_early_present got %b want 0", signal_present); else passes++;
    wave_period(20, 20);
    checks++; if (valid_cnt !== v0 + 1) $display("FAIL restart_valid got %0d want 1", valid_cnt - v0); else passes++;
    checks++; if (period_out !== 20'd40) $display("FAIL restart_period got %0d want 40", period_out); else passes++;
    checks++; if (signal_present !== 1'b1) $display("FAIL restart_present got %b want 1", signal_present); else passes++;
  endtask

  task automatic test_bounds();
    int v0, g0;
    v0 = valid_cnt;
    g0 = glitch_cnt;
    // Intervals 40,100,100,100: edges at exactly MAX_PERIOD must be accepted.
    repeat (4) wave_period(50, 50);
    checks++; if (period_out !== 20'd85) $display("FAIL bound_max_period got %0d want 85", period_out); else passes++;
    checks++; if (signal_present !== 1'b1) $display("FAIL bound_max_present got %b want 1", signal_present); else passes++;
    // Intervals 100,10,10,10 -> 130/4 truncates to 32.
    repeat (4) wave_period(5, 5);
    checks++; if (period_out !== 20'd32) $display("FAIL bound_trunc got %0d want 32", period_out); else passes++;
    repeat (4) wave_period(5, 5);
    checks++; if (period_out !== 20'd10) $display("FAIL bound_min_period got %0d want 10", period_out); else passes++;
    checks++; if (glitch_cnt !== g0) $display("FAIL bound_min_glitch got %0d want 0", glitch_cnt - g0); else passes++;
    checks++; if (valid_cnt !== v0 + 3) $display("FAIL bound_valid_count got %0d want 3", valid_cnt - v0); else passes++;
  endtask

  task automatic test_rst_mid();
    int v0;
    repeat (2) wave_period(20, 20);
    rst = 1'b1;
    step(1);
    checks++; if (period_out !== 20'd0) $display("FAIL rst_mid_period got %0d want 0", period_out); else passes++;
    checks++; if (signal_present !== 1'b0) $display("FAIL rst_mid_present got %b want 0", signal_present); else passes++;
    rst = 1'b0;
    v0 = valid_cnt;
    repeat (4) wave_period(20, 20);
    checks++; if (valid_cnt !== v0) $display("FAIL rst_mid_early_valid got %0d want 0", valid_cnt - v0); else passes++;
    wave_period(20, 20);
    checks++; if (valid_cnt !== v0 + 1) $display("FAIL rst_mid_valid got %0d want 1", valid_cnt - v0); else passes++;
    checks++; if (period_out !== 20'd40) $display("FAIL rst_mid_period_after got %0d want 40", period_out); else passes++;
  endtask

  task automatic test_exclusive();
    checks++; if (collide !== 0) $display("FAIL valid_glitch_overlap got %0d want 0", collide); else passes++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_average();
    test_glitch();
    test_timeout();
    test_bounds();
    test_rst_mid();
    test_exclusive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
